// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared types and funct3 encodings for the memory/writeback stage.
package mem_wb_stage_pkg;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_RSV = 2'd3} wb_sel_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} mw_state_t;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: data-memory req/gnt/rvalid bus between the stage (master) and memory (slave).
interface mem_wb_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                 input dmem_gnt, dmem_rvalid, dmem_rdata);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/mem_wb_stage_lsu_align.sv
// mem_wb_stage_lsu_align: byte-lane steering for stores, load extraction and alignment checking.
module mem_wb_stage_lsu_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_store,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_misalign
);
  logic [31:0] w_sh;
  logic        w_bad;
  always_comb begin
    w_sh       = i_rdata >> {i_addr_lo, 3'b000};
    // unsupported encodings are folded into the misalign path
    w_bad      = i_store ? (i_funct3 > F3_W) : !(i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    o_misalign = w_bad || (i_funct3[1:0] == 2'd1 && i_addr_lo[0]) || (i_funct3[1:0] == 2'd2 && i_addr_lo != 2'd0);
    o_be       = i_funct3[1:0] == 2'd0 ? 4'b0001 << i_addr_lo :
                 i_funct3[1:0] == 2'd1 ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    o_wdata    = i_funct3[1:0] == 2'd0 ? {4{i_wdata[7:0]}} :
                 i_funct3[1:0] == 2'd1 ? {2{i_wdata[15:0]}} : i_wdata;
    o_ldata    = i_funct3 == F3_B  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                 i_funct3 == F3_BU ? {24'd0, w_sh[7:0]} :
                 i_funct3 == F3_H  ? {{16{w_sh[15]}}, w_sh[15:0]} :
                 i_funct3 == F3_HU ? {16'd0, w_sh[15:0]} : w_sh;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access FSM with load/store alignment and register-file writeback.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] inst_in,
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] WD_in,
  input  logic [1:0]      wb_sel,
  input  logic            reg_wr,
  input  logic            wr_en,
  input  logic            rd_en,
  mem_wb_stage_if.master  dmem,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            stall_o,
  output logic            misalign_o,
  output logic            bus_err_o
);
  localparam int CW = $clog2(TIMEOUT + 1) + 1;
  mw_state_t   r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr, r_wdata, r_ldata;
  logic [3:0]  r_be;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [1:0]  r_wb_sel;
  logic        r_we, r_err, r_reg_wr;
  logic        w_idle, w_busy, w_mem, w_mis, w_go, w_tmo, w_gnt, w_cap, w_done_wr;
  logic [2:0]  w_f3;
  logic [1:0]  w_lo, w_sel;
  logic        w_st;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ldata;
  logic        w_unused;
  assign w_unused = ^{inst_in[31:15], inst_in[6:0]};
  always_comb begin
    w_idle = r_state == S_IDLE;
    w_busy = r_state == S_REQ || r_state == S_WAIT;
    w_mem  = rd_en || wr_en;
    // in IDLE the aligner sees the incoming instruction, otherwise the captured one
    w_f3   = w_idle ? inst_in[14:12] : r_funct3;
    w_lo   = w_idle ? alu_in[1:0] : r_addr[1:0];
    w_st   = w_idle ? wr_en : r_we;
    w_go   = w_idle && w_mem && !w_mis;
    w_tmo  = TIMEOUT != 0 && w_busy && r_cnt == CW'(TIMEOUT);
    w_gnt  = r_state == S_REQ && !w_tmo && dmem.dmem_gnt;
    w_cap  = !w_tmo && dmem.dmem_rvalid && (r_state == S_WAIT || w_gnt);
  end
  mem_wb_stage_lsu_align u_align (
    .i_funct3  (w_f3),
    .i_store   (w_st),
    .i_addr_lo (w_lo),
    .i_wdata   (WD_in),
    .i_rdata   (dmem.dmem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_ldata   (w_ldata),
    .o_misalign(w_mis)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = w_go ? S_REQ : S_IDLE;
      S_REQ:   w_next = (w_tmo || (w_gnt && (r_we || dmem.dmem_rvalid))) ? S_DONE : w_gnt ? S_WAIT : S_REQ;
      S_WAIT:  w_next = (w_tmo || dmem.dmem_rvalid) ? S_DONE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    dmem.dmem_req   = r_state == S_REQ && !w_tmo;
    dmem.dmem_we    = r_we;
    dmem.dmem_addr  = {r_addr[31:2], 2'b00};
    dmem.dmem_wdata = r_wdata;
    dmem.dmem_be    = r_be;
    stall_o         = rst && (w_go || w_busy);
    misalign_o      = rst && w_idle && w_mem && w_mis;
    bus_err_o       = w_tmo;
    w_done_wr       = r_state == S_DONE && !r_we && !r_err && r_reg_wr && r_rd != 5'd0;
    rf_we           = rst && (w_idle ? (!w_mem && reg_wr && inst_in[11:7] != 5'd0) : w_done_wr);
    rf_waddr        = !rst ? 5'd0 : w_idle ? inst_in[11:7] : r_rd;
    w_sel           = w_idle ? wb_sel : r_wb_sel;
    rf_wdata        = !rst                          ? '0 :
                      w_sel == WB_ALU               ? alu_in :
                      w_sel == WB_MEM && !w_idle    ? r_ldata :
                      w_sel == WB_PC4               ? pc_in + 32'd4 : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ldata  <= '0;
      r_be     <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_wb_sel <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_reg_wr <= 1'b0;
    end else begin
      if (w_go) begin
        r_cnt    <= '0;
        r_addr   <= alu_in;
        r_wdata  <= w_wdata;
        r_be     <= w_be;
        r_funct3 <= inst_in[14:12];
        r_rd     <= inst_in[11:7];
        r_wb_sel <= wb_sel;
        r_we     <= wr_en;
        r_err    <= 1'b0;
        r_reg_wr <= reg_wr;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_tmo) r_err <= 1'b1;
      if (w_cap) r_ldata <= w_ldata;
    end
  end
endmodule
